// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO: start, LSB-first data, optional parity, stop.
// Latency: pop strobe and start bit appear one cycle after the load edge; frame = (2 + DATA_WIDTH + parity)*P cycles.
// Backpressure: loads only while idle and FIFO non-empty; one pop per frame. Optional: FIFO_UART_TX_TWO_STOP_EN = two stop bits.
module fifo_uart_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      FIFO_EMPTY,
   input  logic [DATA_WIDTH-1:0]     FIFO_RD_DATA,
   output logic                      FIFO_R_INC,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   output logic                      TX_OUT,
   output logic                      BUSY
);

`ifdef FIFO_UART_TX_TWO_STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif

   // Index counter is shared between data bits and stop bits.
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                    state_q;
   logic [PRESCALE_WIDTH-1:0] cnt_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic [IDX_W-1:0]          idx_q;
   logic [DATA_WIDTH-1:0]     shreg_q;
   logic                      par_en_q;
   logic                      par_q;
   logic                      tx_q;
   logic                      busy_q;
   logic                      r_inc_q;

   logic [PRESCALE_WIDTH-1:0] presc_d;
   logic                      par_d;
   logic [DATA_WIDTH-1:0]     shreg_d;
   logic                      bit_end;

   // Load-time values: prescale of zero is promoted to one, parity computed from the word being popped.
   always_comb begin
      presc_d = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
      par_d   = (^FIFO_RD_DATA) ^ PAR_TYP;
      shreg_d = shreg_q >> 1;
      bit_end = (cnt_q == (presc_q - PRESCALE_WIDTH'(1)));
   end

   // Frame sequencer; every output is registered and updated on the same edge as the state change.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         presc_q  <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         r_inc_q  <= 1'b0;
      end else begin
         r_inc_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               cnt_q  <= '0;
               idx_q  <= '0;
               if (!FIFO_EMPTY) begin
                  shreg_q  <= FIFO_RD_DATA;
                  par_en_q <= PAR_EN;
                  par_q    <= par_d;
                  presc_q  <= presc_d;
                  r_inc_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  tx_q     <= 1'b0;
                  state_q  <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  tx_q    <= shreg_q[0];
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                     idx_q <= '0;
                     if (par_en_q) begin
                        tx_q    <= par_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     idx_q   <= idx_q + IDX_W'(1);
                     shreg_q <= shreg_d;
                     tx_q    <= shreg_d[0];
                  end
               end else begin
                  cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
               end
            end
            PARITY: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
               end
            end
            STOP: begin
               tx_q <= 1'b1;
               if (bit_end) begin
                  cnt_q <= '0;
                  if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                     idx_q   <= '0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT     = tx_q;
   assign BUSY       = busy_q;
   assign FIFO_R_INC = r_inc_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, frames compared against an expected bit list.
// Latency: expects start bit and pop strobe in the first cycle after load.
// Backpressure: FIFO model pops only on the strobe and records any pop while empty.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_TWO_STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif

   logic       CLK;
   logic       RST;
   logic       FIFO_EMPTY;
   logic [7:0] FIFO_RD_DATA;
   logic       FIFO_R_INC;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] PRESCALE;
   logic       TX_OUT;
   logic       BUSY;

   int n_cmp = 0;
   int n_err = 0;

   // FIFO model: words pushed by the stimulus, popped on the strobe
   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         pops = 0;
   int         underflows = 0;

   assign FIFO_EMPTY   = (rd_ptr == wr_ptr);
   assign FIFO_RD_DATA = mem[rd_ptr[5:0]];

   fifo_uart_tx #(
      .DATA_WIDTH    (8),
      .PRESCALE_WIDTH(6)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .FIFO_EMPTY  (FIFO_EMPTY),
      .FIFO_RD_DATA(FIFO_RD_DATA),
      .FIFO_R_INC  (FIFO_R_INC),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .PRESCALE    (PRESCALE),
      .TX_OUT      (TX_OUT),
      .BUSY        (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Pop on the strobe; a strobe against an empty FIFO is an underflow
   always @(posedge CLK) begin
      if (FIFO_R_INC === 1'b1) begin
         if (rd_ptr == wr_ptr) underflows <= underflows + 1;
         else rd_ptr <= rd_ptr + 1;
         pops <= pops + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr++;
   endtask

   // Waits for the frame to start, then checks every cycle against the expected bit list.
   task automatic expect_frame(input string tag, input logic [7:0] w, input int p_in,
                               input bit pe, input bit pt, input int chg_cyc,
                               input int chg_val, output int waited);
      bit exp_bits[$];
      int p;
      int cyc;
      int busy_n;
      bit found;
      p      = (p_in == 0) ? 1 : p_in;
      waited = 0;
      found  = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge CLK);
         if (BUSY === 1'b1) begin
            found = 1'b1;
            break;
         end
         waited++;
      end
      if (!found) begin
         chk({tag, "_start_timeout"}, 32'(BUSY), 32'd1);
         return;
      end
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
      if (pe) exp_bits.push_back((^w) ^ pt);
      for (int i = 0; i < STOP_BITS; i++) exp_bits.push_back(1'b1);
      cyc    = 0;
      busy_n = 0;
      foreach (exp_bits[i]) begin
         for (int k = 0; k < p; k++) begin
            if (cyc > 0) @(negedge CLK);
            if (cyc == chg_cyc) PRESCALE = 6'(chg_val);
            chk({tag, "_tx"}, 32'(TX_OUT), 32'(exp_bits[i]));
            chk({tag, "_rinc"}, 32'(FIFO_R_INC), 32'(cyc == 0));
            if (BUSY === 1'b1) busy_n++;
            cyc++;
         end
      end
      @(negedge CLK);
      chk({tag, "_busy_len"}, 32'(busy_n), 32'((2 + 8 + int'(pe) + STOP_BITS - 1) * p));
      chk({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
      chk({tag, "_idle_tx"}, 32'(TX_OUT), 32'd1);
   endtask

   initial begin
      int waited;
      int base;
      logic [7:0] w;
      logic [7:0] w2;
      bit pe;
      bit pt;
      int p;

      RST      = 1'b0;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      PRESCALE = 6'd4;

      // Held in reset with a word waiting: line idle, no pop
      push(8'hA5);
      repeat (5) begin
         @(negedge CLK);
         chk("rst_tx", 32'(TX_OUT), 32'd1);
         chk("rst_busy", 32'(BUSY), 32'd0);
         chk("rst_rinc", 32'(FIFO_R_INC), 32'd0);
      end
      RST = 1'b1;
      expect_frame("a5", 8'hA5, 4, 1'b0, 1'b0, -1, 0, waited);
      chk("a5_first_edge", 32'(waited), 32'd0);
      chk("a5_pops", 32'(pops), 32'd1);

      // Parity even then odd on 8'h07 at one cycle per bit
      PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd1;
      push(8'h07);
      expect_frame("par_even", 8'h07, 1, 1'b1, 1'b0, -1, 0, waited);
      PAR_TYP = 1'b1;
      push(8'h07);
      expect_frame("par_odd", 8'h07, 1, 1'b1, 1'b1, -1, 0, waited);

      // Three queued words go out back to back, then the line stays idle
      PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd2;
      base = pops;
      push(8'h01); push(8'h80); push(8'hFF);
      expect_frame("b2b0", 8'h01, 2, 1'b0, 1'b0, -1, 0, waited);
      expect_frame("b2b1", 8'h80, 2, 1'b0, 1'b0, -1, 0, waited);
      chk("b2b1_gap", 32'(waited), 32'd0);
      expect_frame("b2b2", 8'hFF, 2, 1'b0, 1'b0, -1, 0, waited);
      chk("b2b2_gap", 32'(waited), 32'd0);
      repeat (15) @(negedge CLK);
      chk("b2b_pops", 32'(pops - base), 32'd3);
      chk("b2b_idle_busy", 32'(BUSY), 32'd0);
      chk("b2b_empty", 32'(FIFO_EMPTY), 32'd1);

      // Prescale zero runs at one cycle per bit
      PRESCALE = 6'd0;
      w = 8'($urandom);
      push(w);
      expect_frame("p0", w, 0, 1'b0, 1'b0, -1, 0, waited);

      // Prescale change mid-frame only affects the following frame
      PRESCALE = 6'd2;
      w  = 8'($urandom);
      w2 = 8'($urandom);
      push(w); push(w2);
      expect_frame("chg_a", w, 2, 1'b0, 1'b0, 3, 8, waited);
      expect_frame("chg_b", w2, 8, 1'b0, 1'b0, -1, 0, waited);
      chk("chg_b_gap", 32'(waited), 32'd0);

      // Randomized frames
      for (int n = 0; n < 24; n++) begin
         w  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         p  = int'($urandom_range(0, 7));
         PAR_EN = pe; PAR_TYP = pt; PRESCALE = 6'(p);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge CLK);
         push(w);
         expect_frame("rnd", w, p, pe, pt, -1, 0, waited);
      end

      // Reset in the middle of the data bits aborts the frame
      PAR_EN = 1'b0; PRESCALE = 6'd4;
      base = pops;
      push(8'h00);
      expect_frame("pre_abort", 8'h00, 4, 1'b0, 1'b0, -1, 0, waited);
      push(8'h00);
      for (int t = 0; t < 20 && BUSY !== 1'b1; t++) @(negedge CLK);
      repeat (10) @(negedge CLK);
      chk("abort_pre_tx", 32'(TX_OUT), 32'd0);
      #1 RST = 1'b0;
      #1;
      chk("abort_tx", 32'(TX_OUT), 32'd1);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_rinc", 32'(FIFO_R_INC), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (20) @(negedge CLK);
      chk("abort_pops", 32'(pops - base), 32'd2);
      chk("abort_idle_busy", 32'(BUSY), 32'd0);
      chk("abort_idle_tx", 32'(TX_OUT), 32'd1);

      chk("no_underflow", 32'(underflows), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
